// File: rtl/cordic_vectoring_engine.sv
// cordic_vectoring_engine
// Sequential CORDIC vectoring engine: turns a Cartesian vector (x, y) into a
// magnitude and an atan2 angle.
// It performs one circular-mode micro-rotation per clock. The rotation
// direction comes from the sign of the running y.
//
// Optional build macro:
//   GAIN_COMP_EN - adds a one-cycle GAIN state that scales the magnitude by
//                  about 1/K (0.607422), so mag_out approximates |v|.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input vector valid
//   in_ready   out  engine idle and able to accept a vector
//   x_in       in   signed x, Q2.14
//   y_in       in   signed y, Q2.14
//   out_valid  out  result valid (held until out_ready)
//   out_ready  in   consumer accepts the result
//   mag_out    out  signed magnitude, Q2.14
//   angle_out  out  signed angle, binary radians (LSB = pi/32768)
module cordic_vectoring_engine #(
  parameter int FIXED_WIDTH = 16,
  parameter int ITERATIONS  = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [FIXED_WIDTH-1:0] x_in,
  input  logic signed [FIXED_WIDTH-1:0] y_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [FIXED_WIDTH-1:0] mag_out,
  output logic signed [FIXED_WIDTH-1:0] angle_out
);

  typedef enum logic [1:0] {IDLE, ITER, GAIN, DONE} state_t;

  state_t                        state;
  logic [3:0]                    iter_cnt;
  logic signed [FIXED_WIDTH-1:0] x_reg;
  logic signed [FIXED_WIDTH-1:0] y_reg;
  logic signed [FIXED_WIDTH-1:0] z_reg;
  logic                          zero_flag;

  logic signed [FIXED_WIDTH-1:0] x_shift;
  logic signed [FIXED_WIDTH-1:0] y_shift;
  logic signed [FIXED_WIDTH-1:0] delta_z;
  logic signed [FIXED_WIDTH-1:0] x_next;
  logic signed [FIXED_WIDTH-1:0] y_next;
  logic signed [FIXED_WIDTH-1:0] z_next;
  logic                          last_iter;

  // Arctangent table, atan(2^-i) in binary radians (pi/32768 per LSB)
  function automatic logic signed [FIXED_WIDTH-1:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'sd8192;
      4'd1:    atan_lut = 16'sd4836;
      4'd2:    atan_lut = 16'sd2555;
      4'd3:    atan_lut = 16'sd1297;
      4'd4:    atan_lut = 16'sd651;
      4'd5:    atan_lut = 16'sd326;
      4'd6:    atan_lut = 16'sd163;
      4'd7:    atan_lut = 16'sd81;
      4'd8:    atan_lut = 16'sd41;
      4'd9:    atan_lut = 16'sd20;
      4'd10:   atan_lut = 16'sd10;
      4'd11:   atan_lut = 16'sd5;
      4'd12:   atan_lut = 16'sd3;
      4'd13:   atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  assign in_ready  = (state == IDLE);
  assign last_iter = (iter_cnt == 4'(ITERATIONS - 1));
  assign x_shift   = x_reg >>> iter_cnt;
  assign y_shift   = y_reg >>> iter_cnt;
  assign delta_z   = atan_lut(iter_cnt);

  // One circular micro-rotation. A negative y rotates counter-clockwise to
  // drive y toward zero, while z accumulates the angle already rotated through.
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    z_next = z_reg;
    if (y_reg[FIXED_WIDTH-1]) begin
      x_next = x_reg - y_shift;
      y_next = y_reg + x_shift;
      z_next = z_reg - delta_z;
    end else begin
      x_next = x_reg + y_shift;
      y_next = y_reg - x_shift;
      z_next = z_reg + delta_z;
    end
  end

`ifdef GAIN_COMP_EN
  logic signed [FIXED_WIDTH-1:0] gain_x;

  // Shift-add approximation of 1/K: 1/2 + 1/8 - 1/64 - 1/512 = 0.607422
  assign gain_x = (x_reg >>> 1) + (x_reg >>> 3) - (x_reg >>> 6) - (x_reg >>> 9);
`endif

  // Control FSM and datapath registers. Vectors with x < 0 are pre-rotated
  // by +/-90 degrees into the right half-plane, because the iterations only
  // converge within about +/-99 degrees. The results are loaded into the
  // output registers on the transition into DONE and are held there until
  // the handshake completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      iter_cnt  <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      zero_flag <= 1'b0;
      out_valid <= 1'b0;
      mag_out   <= '0;
      angle_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            iter_cnt  <= '0;
            zero_flag <= (x_in == '0) && (y_in == '0);
            if (!x_in[FIXED_WIDTH-1]) begin
              x_reg <= x_in;
              y_reg <= y_in;
              z_reg <= '0;
            end else if (!y_in[FIXED_WIDTH-1]) begin
              x_reg <= y_in;
              y_reg <= -x_in;
              z_reg <= 16'sd16384;
            end else begin
              x_reg <= -y_in;
              y_reg <= x_in;
              z_reg <= -16'sd16384;
            end
            state <= ITER;
          end
        end
        ITER: begin
          x_reg    <= x_next;
          y_reg    <= y_next;
          z_reg    <= z_next;
          iter_cnt <= iter_cnt + 4'd1;
          if (last_iter) begin
`ifdef GAIN_COMP_EN
            state <= GAIN;
`else
            state     <= DONE;
            out_valid <= 1'b1;
            mag_out   <= zero_flag ? '0 : x_next;
            angle_out <= zero_flag ? '0 : z_next;
`endif
          end
        end
`ifdef GAIN_COMP_EN
        GAIN: begin
          x_reg     <= gain_x;
          state     <= DONE;
          out_valid <= 1'b1;
          mag_out   <= zero_flag ? '0 : gain_x;
          angle_out <= zero_flag ? '0 : z_reg;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
